// File: rtl/ofm_write_back_if.sv
// ofm_write_back_if: capture/stream bundle between the controller + PE array
// (master side) and the OFM write-back stage (slave side).
//   write_out_en : capture strobe, single-cycle pulse
//   pe_out       : SYSTOLIC_SIZE packed signed psums, element i at [i*PSUM_WIDTH +: PSUM_WIDTH]
//   busy/ofm_we  : drain in progress / OFM write enable (always equal)
//   ofm_addr     : OFM write address
//   ofm_data     : requantized word
//   layer_done   : pulse on the write to the last address of the layer
//   overflow     : sticky dropped-strobe flag
interface ofm_write_back_if #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int PSUM_WIDTH    = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 10
);
  logic                                  write_out_en;
  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0]   pe_out;
  logic                                  busy;
  logic                                  ofm_we;
  logic [ADDR_WIDTH-1:0]                 ofm_addr;
  logic [DATA_WIDTH-1:0]                 ofm_data;
  logic                                  layer_done;
  logic                                  overflow;

  modport master (
    output write_out_en, pe_out,
    input  busy, ofm_we, ofm_addr, ofm_data, layer_done, overflow
  );

  modport slave (
    input  write_out_en, pe_out,
    output busy, ofm_we, ofm_addr, ofm_data, layer_done, overflow
  );
endinterface

// File: rtl/ofm_write_back.sv
// ofm_write_back: captures SYSTOLIC_SIZE psums on a strobe, requantizes each
// (>>> FRAC_SHIFT, leaky ReLU by >>> LEAKY_SHIFT, saturate to DATA_WIDTH) and
// streams them one per cycle to OFM memory with a wrapping address.
//   clk, rst_n : clock, async active-low reset
//   bus        : ofm_write_back_if slave modport (strobe/psums in, OFM write port out)
module ofm_write_back #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int PSUM_WIDTH    = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_SHIFT    = 8,
  parameter int LEAKY_SHIFT   = 3,
  parameter int OFM_SIZE      = 1024,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  ofm_write_back_if.slave  bus
);
  localparam int IDX_W = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(SYSTOLIC_SIZE-1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OFM_SIZE-1);
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX =
    {{(PSUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN =
    {{(PSUM_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  // Floor shift, leaky slope on negatives, then clip to the signed word range.
  function automatic logic [DATA_WIDTH-1:0] requant(input logic [PSUM_WIDTH-1:0] p);
    logic signed [PSUM_WIDTH-1:0] s;
    logic signed [PSUM_WIDTH-1:0] l;
    logic [DATA_WIDTH-1:0]        q;
    s = $signed(p) >>> FRAC_SHIFT;
    l = s[PSUM_WIDTH-1] ? (s >>> LEAKY_SHIFT) : s;
    if (l > SAT_MAX)      q = SAT_MAX[DATA_WIDTH-1:0];
    else if (l < SAT_MIN) q = SAT_MIN[DATA_WIDTH-1:0];
    else                  q = l[DATA_WIDTH-1:0];
    return q;
  endfunction

  state_t                                 r_state, w_nxt_state;
  logic [SYSTOLIC_SIZE-1:0][PSUM_WIDTH-1:0] r_shadow;
  logic [IDX_W-1:0]                       r_idx;     // element currently on the output
  logic [ADDR_WIDTH-1:0]                  r_wptr;    // address of the next write
  logic                                   r_we, r_done, r_ovf;
  logic [ADDR_WIDTH-1:0]                  r_addr;
  logic [DATA_WIDTH-1:0]                  r_data;

  logic                  w_last, w_capture, w_emit, w_drop;
  logic [IDX_W-1:0]      w_nxt_idx;
  logic [PSUM_WIDTH-1:0] w_psel;

  // Outputs are registered, so the word emitted after a capture edge must be
  // taken straight from pe_out; the shadow only serves the later elements.
  always_comb begin
    w_last      = 1'b0;
    w_capture   = 1'b0;
    w_emit      = 1'b0;
    w_drop      = 1'b0;
    w_nxt_idx   = r_idx + 1'b1;
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: begin
        w_capture = bus.write_out_en;
      end
      S_DRAIN: begin
        w_last    = (r_idx == LAST_IDX);
        w_capture = bus.write_out_en && w_last;
        w_drop    = bus.write_out_en && !w_last;
      end
      default: ;
    endcase
    w_emit = w_capture || (r_state == S_DRAIN && !w_last);
    if (w_capture) w_nxt_idx = '0;
    w_nxt_state = w_emit ? S_DRAIN : S_IDLE;
    w_psel = w_capture ? bus.pe_out[PSUM_WIDTH-1:0] : r_shadow[w_nxt_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_idx    <= '0;
      r_wptr   <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      if (w_capture) r_shadow <= bus.pe_out;
      if (w_drop)    r_ovf    <= 1'b1;
      if (w_emit) begin
        r_idx  <= w_nxt_idx;
        r_we   <= 1'b1;
        r_addr <= r_wptr;
        r_data <= requant(w_psel);
        r_done <= (r_wptr == LAST_ADDR);
        r_wptr <= (r_wptr == LAST_ADDR) ? '0 : r_wptr + 1'b1;
      end else begin
        r_we   <= 1'b0;
        r_done <= 1'b0;
        r_addr <= '0;
        r_data <= '0;
      end
    end
  end

  assign bus.busy       = r_we;
  assign bus.ofm_we     = r_we;
  assign bus.ofm_addr   = r_addr;
  assign bus.ofm_data   = r_data;
  assign bus.layer_done = r_done;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_ofm_write_back.sv
module tb_ofm_write_back;
  localparam int S  = 16;
  localparam int PW = 32;
  localparam int DW = 16;
  localparam int AW = 10;

  logic clk, rst_n;
  int total = 0;
  int bad   = 0;

  ofm_write_back_if #(.SYSTOLIC_SIZE(S), .PSUM_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ofm_write_back #(.SYSTOLIC_SIZE(S), .PSUM_WIDTH(PW), .DATA_WIDTH(DW), .FRAC_SHIFT(8),
                   .LEAKY_SHIFT(3), .OFM_SIZE(1024), .ADDR_WIDTH(AW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // element i = (base+i+1) << 8, so requantized word = base+i+1
  function automatic logic [S*PW-1:0] ramp(input int base);
    logic [S*PW-1:0] v;
    v = '0;
    for (int i = 0; i < S; i++) v[i*PW +: PW] = PW'((base + i + 1) << 8);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.write_out_en = 1'b0;
    bus.pe_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drive at a negedge, sampled by the next posedge; word 0 visible at the next negedge
  task automatic strobe(input logic [S*PW-1:0] v);
    @(negedge clk);
    bus.write_out_en = 1'b1;
    bus.pe_out = v;
    @(negedge clk);
    bus.write_out_en = 1'b0;
    bus.pe_out = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.write_out_en = 1'b0;
    bus.pe_out = '0;
    #1;
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.ofm_we !== 1'b0)     begin bad++; $display("FAIL reset_we got=%b exp=0", bus.ofm_we); end
    total++; if (bus.ofm_addr !== '0)     begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.ofm_addr); end
    total++; if (bus.ofm_data !== '0)     begin bad++; $display("FAIL reset_data got=%h exp=0", bus.ofm_data); end
    total++; if (bus.layer_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.layer_done); end
    total++; if (bus.overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    strobe(ramp(0));
    for (int i = 0; i < S; i++) begin
      total++; if (bus.ofm_we !== 1'b1 || bus.busy !== 1'b1)
        begin bad++; $display("FAIL single_we[%0d] got we=%b busy=%b exp=1", i, bus.ofm_we, bus.busy); end
      total++; if (bus.ofm_addr !== AW'(i))
        begin bad++; $display("FAIL single_addr[%0d] got=%0d exp=%0d", i, bus.ofm_addr, i); end
      total++; if (bus.ofm_data !== DW'(i + 1))
        begin bad++; $display("FAIL single_data[%0d] got=%0d exp=%0d", i, bus.ofm_data, i + 1); end
      total++; if (bus.layer_done !== 1'b0)
        begin bad++; $display("FAIL single_done[%0d] got=%b exp=0", i, bus.layer_done); end
      @(negedge clk);
    end
    total++; if (bus.busy !== 1'b0 || bus.ofm_we !== 1'b0 || bus.layer_done !== 1'b0)
      begin bad++; $display("FAIL single_end got busy=%b we=%b done=%b exp=0", bus.busy, bus.ofm_we, bus.layer_done); end
  endtask

  task automatic test_requant();
    logic [S*PW-1:0] v;
    int exp_d [4];
    v = '0;
    v[0*PW +: PW] = PW'(-2048);
    v[1*PW +: PW] = 32'h7FFF_FF00;
    v[2*PW +: PW] = 32'h8000_0100;   // -0x7FFFFF00
    v[3*PW +: PW] = 32'hFFFF_FFFF;   // -1
    exp_d[0] = -1; exp_d[1] = 32767; exp_d[2] = -32768; exp_d[3] = -1;
    do_reset();
    strobe(v);
    for (int i = 0; i < S; i++) begin
      total++; if (bus.ofm_data !== DW'((i < 4) ? exp_d[i] : 0) || bus.ofm_we !== 1'b1)
        begin bad++; $display("FAIL requant[%0d] got data=%h we=%b exp=%h", i, bus.ofm_data, bus.ofm_we, DW'((i < 4) ? exp_d[i] : 0)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    strobe(ramp(0));
    for (int w = 0; w < 4 * S; w++) begin
      total++; if (bus.ofm_we !== 1'b1 || bus.ofm_addr !== AW'(w) || bus.ofm_data !== DW'(w + 1) || bus.overflow !== 1'b0)
        begin bad++; $display("FAIL b2b[%0d] got we=%b addr=%0d data=%0d ovf=%b exp we=1 addr=%0d data=%0d ovf=0",
                              w, bus.ofm_we, bus.ofm_addr, bus.ofm_data, bus.overflow, w, w + 1); end
      if ((w % S) == S - 1 && w < 4 * S - 1) begin
        bus.write_out_en = 1'b1;
        bus.pe_out = ramp(w + 1);
      end else begin
        bus.write_out_en = 1'b0;
        bus.pe_out = '0;
      end
      @(negedge clk);
    end
    total++; if (bus.ofm_we !== 1'b0 || bus.overflow !== 1'b0)
      begin bad++; $display("FAIL b2b_end got we=%b ovf=%b exp 0 0", bus.ofm_we, bus.overflow); end
  endtask

  task automatic test_early_strobe();
    do_reset();
    strobe(ramp(0));
    for (int i = 0; i < S; i++) begin
      total++; if (bus.ofm_we !== 1'b1 || bus.ofm_addr !== AW'(i) || bus.ofm_data !== DW'(i + 1))
        begin bad++; $display("FAIL early[%0d] got we=%b addr=%0d data=%0d exp we=1 addr=%0d data=%0d",
                              i, bus.ofm_we, bus.ofm_addr, bus.ofm_data, i, i + 1); end
      if (i == 4) begin
        bus.write_out_en = 1'b1;
        bus.pe_out = ramp(100);
      end else begin
        bus.write_out_en = 1'b0;
        bus.pe_out = '0;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      total++; if (bus.ofm_we !== 1'b0 || bus.overflow !== 1'b1)
        begin bad++; $display("FAIL early_after[%0d] got we=%b ovf=%b exp we=0 ovf=1", k, bus.ofm_we, bus.overflow); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    total++; if (bus.overflow !== 1'b0)
      begin bad++; $display("FAIL early_ovf_clear got=%b exp=0", bus.overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_layer_wrap();
    int ndone;
    ndone = 0;
    do_reset();
    strobe(ramp(0));
    for (int w = 0; w < 65 * S; w++) begin
      total++; if (bus.ofm_we !== 1'b1 || bus.ofm_addr !== AW'(w % 1024) || bus.layer_done !== ((w % 1024) == 1023))
        begin bad++; $display("FAIL wrap[%0d] got we=%b addr=%0d done=%b exp addr=%0d done=%b",
                              w, bus.ofm_we, bus.ofm_addr, bus.layer_done, w % 1024, (w % 1024) == 1023); end
      if (bus.layer_done === 1'b1) ndone++;
      if ((w % S) == S - 1 && w < 65 * S - 1) begin
        bus.write_out_en = 1'b1;
        bus.pe_out = ramp(0);
      end else begin
        bus.write_out_en = 1'b0;
        bus.pe_out = '0;
      end
      @(negedge clk);
    end
    total++; if (ndone != 1)
      begin bad++; $display("FAIL wrap_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    strobe(ramp(0));
    repeat (7) @(negedge clk);
    total++; if (bus.ofm_addr !== AW'(7))
      begin bad++; $display("FAIL mid_pre got addr=%0d exp=7", bus.ofm_addr); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.ofm_we !== 1'b0 || bus.ofm_addr !== '0 ||
                 bus.ofm_data !== '0 || bus.layer_done !== 1'b0 || bus.overflow !== 1'b0)
      begin bad++; $display("FAIL mid_reset got busy=%b we=%b addr=%0d data=%0d done=%b ovf=%b exp all 0",
                            bus.busy, bus.ofm_we, bus.ofm_addr, bus.ofm_data, bus.layer_done, bus.overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    strobe(ramp(20));
    total++; if (bus.ofm_we !== 1'b1 || bus.ofm_addr !== '0 || bus.ofm_data !== DW'(21))
      begin bad++; $display("FAIL mid_restart got we=%b addr=%0d data=%0d exp we=1 addr=0 data=21",
                            bus.ofm_we, bus.ofm_addr, bus.ofm_data); end
    repeat (S) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.write_out_en = 1'b0;
    bus.pe_out = '0;
    test_reset();
    test_single();
    test_requant();
    test_back_to_back();
    test_early_strobe();
    test_layer_wrap();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
